vga_scan_driver: RTL

//  Raster-side end of the sprite pixel interface: generates the VGA scan position (x,y)

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_pix_div.sv | 28 ++
 rtl/vga_scan_driver.sv | 123 ++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing, derived sync windows, and pixel-interface sizes
// shared by the scan driver and its clock divider.
package vga_timing_pkg;

    localparam int CLK_DIV  = 4;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Inclusive sync windows in scan-counter units
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam int RGB_W    = 12;
    localparam int N_LAYERS = 3;
    localparam int CNT_W    = 10;

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: free-running 0..CLK_DIV-1 counter with a registered
// pix_tick that is high exactly in the clk where the counter sits at CLK_DIV-1.
module vga_pix_div #(
    parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic pix_tick
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

    logic [DIV_W-1:0] div_cnt_reg;

    // Wrapping divider; pix_tick is decoded one count early so it lines up with DIV_LAST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg <= '0;
            pix_tick    <= 1'b0;
        end else begin
            div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
            pix_tick    <= (div_cnt_reg == DIV_PRE);
        end
    end

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster generator: scan counters (x,y), per-frame tick, and a one-pixel
// output stage that composites up to three priority-ordered sprite layers over
// a background and drives hsync/vsync/RGB aligned with each other.
module vga_scan_driver
    import vga_timing_pkg::RGB_W, vga_timing_pkg::N_LAYERS, vga_timing_pkg::CNT_W;
#(
    parameter int CLK_DIV  = vga_timing_pkg::CLK_DIV,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter logic [RGB_W-1:0] BG_RGB = 12'h000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_LAYERS-1:0]       layer_en,
    input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
    output logic [CNT_W-1:0]          x,
    output logic [CNT_W-1:0]          y,
    output logic                      pix_tick,
    output logic                      frame_tick,
    output logic                      hsync,
    output logic                      vsync,
    output logic [RGB_W-1:0]          vga_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] X_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACTIVE_C = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACTIVE_C = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] x_reg, y_reg;
    logic             x_last, y_last;
    logic [RGB_W-1:0] layer_col [N_LAYERS];
    logic [RGB_W-1:0] rgb_reg, rgb_next;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic             active;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk      (clk),
        .rst      (rst),
        .pix_tick (pix_tick)
    );

    assign x_last = (x_reg == X_LAST);
    assign y_last = (y_reg == Y_LAST);

    // The frame tick coincides with the pix_tick that wraps the scan back to (0,0)
    assign frame_tick = pix_tick & x_last & y_last;

    // Split the packed layer colour bus into one word per layer
    generate
        for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_layer
            assign layer_col[gi] = layer_rgb[gi*RGB_W +: RGB_W];
        end
    endgenerate

    // Raster counters: x runs along the line, y steps once per line wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (pix_tick) begin
            if (x_last) begin
                x_reg <= '0;
                y_reg <= y_last ? '0 : y_reg + 1'b1;
            end else begin
                x_reg <= x_reg + 1'b1;
            end
        end
    end

    // Pixel decode for the current position: priority mux, blanking and sync windows
    always_comb begin
        rgb_next   = BG_RGB;
        active     = (x_reg < H_ACTIVE_C) && (y_reg < V_ACTIVE_C);
        // Walk from lowest priority upward so the lowest enabled index overrides
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (layer_en[i]) begin
                rgb_next = layer_col[i];
            end
        end
        if (!active) begin
            rgb_next = '0;
        end
        hsync_next = !((x_reg >= HS_START_C) && (x_reg <= HS_END_C));
        vsync_next = !((y_reg >= VS_START_C) && (y_reg <= VS_END_C));
    end

    // Pin register: colour and both syncs share one pixel of delay to stay aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_reg   <= '0;
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
        end else if (pix_tick) begin
            rgb_reg   <= rgb_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
        end
    end

    assign x       = x_reg;
    assign y       = y_reg;
    assign vga_rgb = rgb_reg;
    assign hsync   = hsync_reg;
    assign vsync   = vsync_reg;

endmodule
